// File: rtl/shake_absorb_arbiter_pkg.sv
// Shared constants and types for the SHAKE absorb arbiter: rates, state width,
// FSM encodings and the registered response bundle.
package shake_absorb_arbiter_pkg;

  localparam int          STATE_W       = 1600;
  localparam logic [31:0] SHAKE128_RATE = 32'd168;
  localparam logic [31:0] SHAKE256_RATE = 32'd136;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [STATE_W-1:0] s;
    logic [31:0]        pos;
  } absorb_rsp_t;

  function automatic logic [31:0] rate_of(input logic sel);
    return sel ? SHAKE256_RATE : SHAKE128_RATE;
  endfunction

endpackage

// File: rtl/shake_absorb_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after rr_ptr, cyclic.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  int idx;

  // Scan offsets from the far end down so the nearest hit to rr_ptr wins.
  always_comb begin
    gnt_idx = '0;
    idx     = 0;
    any     = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) gnt_idx = IW'(idx);
    end
  end

endmodule

// File: rtl/shake_absorb_arbiter.sv
// Shares one keccak_absorb engine between NREQ requesters: round-robin grant,
// start pulse, wait for done, register result, one-cycle ack.
module shake_absorb_arbiter
  import shake_absorb_arbiter_pkg::*;
#(
  parameter int in_len = 32,
  parameter int NREQ   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           rate_sel,
  input  logic [NREQ*STATE_W-1:0]   s_in,
  input  logic [NREQ*32-1:0]        pos_in,
  input  logic [NREQ*in_len*8-1:0]  msg_in,
  input  logic [NREQ*64-1:0]        inlen_in,
  output logic [NREQ-1:0]           ack,
  output logic [STATE_W-1:0]        s_out,
  output logic [31:0]               pos_out,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      core_start,
  output logic [STATE_W-1:0]        core_s_in,
  output logic [31:0]               core_pos,
  output logic [31:0]               core_r,
  output logic [in_len*8-1:0]       core_in,
  output logic [63:0]               core_inlen,
  input  logic [STATE_W-1:0]        core_s_out,
  input  logic [31:0]               core_pos_out,
  input  logic                      core_done
);

  localparam int IW = $clog2(NREQ);
  localparam int MW = in_len * 8;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  absorb_rsp_t   rsp_q;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      rsp_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_any) begin
          grant_id <= pick_idx;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: state <= ST_WAIT;
        // A done seen in any other state is stray and dropped.
        ST_WAIT: if (core_done) begin
          rsp_q <= '{s: core_s_out, pos: core_pos_out};
          state <= ST_RESP;
        end
        default: begin
          rr_ptr <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_start = (state == ST_ISSUE);
  assign busy       = (state != ST_IDLE);
  assign s_out      = rsp_q.s;
  assign pos_out    = rsp_q.pos;

  always_comb begin
    ack = '0;
    if (state == ST_RESP) ack[grant_id] = 1'b1;
  end

  // Operand mux keys off the registered grant, so it is stable ISSUE..WAIT.
  assign core_s_in  = s_in[grant_id*STATE_W +: STATE_W];
  assign core_pos   = pos_in[grant_id*32 +: 32];
  assign core_in    = msg_in[grant_id*MW +: MW];
  assign core_inlen = inlen_in[grant_id*64 +: 64];
  assign core_r     = rate_of(rate_sel[grant_id]);

endmodule
